// File: rtl/smap_smep_fault_queue.sv
// Fault queue between the SMEP/SMAP permission checkers and the trap controller.
// Buffers fault syndromes oldest-first and keeps a saturating count plus a sticky overflow flag.
module smap_smep_fault_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned VA_W  = 64,
    parameter int unsigned TAG_W = 6,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fault_i,
    input  logic             fault_exec_i,
    input  logic [VA_W-1:0]  fault_va_i,
    input  logic [TAG_W-1:0] fault_tag_i,
    input  logic             flush_i,
    output logic             trap_valid_o,
    input  logic             trap_ready_i,
    output logic [1:0]       trap_cause_o,
    output logic [VA_W-1:0]  trap_va_o,
    output logic [TAG_W-1:0] trap_tag_o,
    output logic             overflow_o,
    input  logic             clr_overflow_i,
    output logic [CNT_W-1:0] fault_count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] OCC_FULL = (PTR_W + 1)'(DEPTH);

    logic [1:0]       r_cause [DEPTH];
    logic [VA_W-1:0]  r_va    [DEPTH];
    logic [TAG_W-1:0] r_tag   [DEPTH];

    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [PTR_W:0]   r_occ;
    logic             r_overflow;
    logic [CNT_W-1:0] r_count;

    logic w_valid;
    logic w_full;
    logic w_deq;
    logic w_enq;
    logic w_drop;

    assign w_valid = (r_occ != '0);
    assign w_full  = (r_occ == OCC_FULL);
    assign w_deq   = w_valid & trap_ready_i;
    // A pop in the same cycle frees the slot, so a full queue still accepts the push.
    assign w_enq   = fault_i & ~flush_i & (~w_full | w_deq);
    assign w_drop  = fault_i & ~flush_i & w_full & ~w_deq;

    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_cause[r_wptr] <= fault_exec_i ? 2'b01 : 2'b10;
            r_va[r_wptr]    <= fault_va_i;
            r_tag[r_wptr]   <= fault_tag_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_occ  <= '0;
        end else if (flush_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_occ  <= '0;
        end else begin
            if (w_enq) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_deq) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (w_enq && !w_deq) begin
                r_occ <= r_occ + 1'b1;
            end else if (!w_enq && w_deq) begin
                r_occ <= r_occ - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
            r_count    <= '0;
        end else begin
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (clr_overflow_i) begin
                r_overflow <= 1'b0;
            end
            if (fault_i && (r_count != '1)) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    always_comb begin
        trap_valid_o = w_valid;
        trap_cause_o = '0;
        trap_va_o    = '0;
        trap_tag_o   = '0;
        if (w_valid) begin
            trap_cause_o = r_cause[r_rptr];
            trap_va_o    = r_va[r_rptr];
            trap_tag_o   = r_tag[r_rptr];
        end
    end

    assign overflow_o    = r_overflow;
    assign fault_count_o = r_count;

endmodule
